// File: rtl/bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// bus_arbiter_mux
//   Registered N-source common-bus multiplexer. Sits between the register
//   file / memory / ALU sources and the shared datapath bus.
//     MODE=0 : direct mode, the control unit picks the source with SEL.
//     MODE=1 : round-robin arbitration over REQ, with a hold limit of
//              MAX_HOLD consecutive cycles while another source is waiting.
//
// Ports
//   CLK      in   1        clock, rising edge
//   RST      in   1        asynchronous active-high reset
//   MODE     in   1        0 = direct select, 1 = round-robin arbitration
//   SEL      in   SEL_W    direct-mode source index
//   REQ      in   N        per-source bus request (arbitrated mode only)
//   IN       in   N*SIZE   flattened source data, source i = IN[i*SIZE +: SIZE]
//   OUT      out  SIZE     registered bus value
//   VALID    out  1        OUT holds data from a selected/granted source
//   GNT      out  N        one-hot owner, zero when there is no owner
//   GNT_IDX  out  SEL_W    binary owner index, zero when there is no owner
// -----------------------------------------------------------------------------
module bus_arbiter_mux #(
    parameter int SIZE     = 32,
    parameter int N        = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MODE,
    input  logic [SEL_W-1:0]    SEL,
    input  logic [N-1:0]        REQ,
    input  logic [N*SIZE-1:0]   IN,
    output logic [SIZE-1:0]     OUT,
    output logic                VALID,
    output logic [N-1:0]        GNT,
    output logic [SEL_W-1:0]    GNT_IDX
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [SEL_W:0]    N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [SEL_W-1:0]    ptr, ptr_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;

    logic [SIZE-1:0]     out_n;
    logic                valid_n;
    logic [N-1:0]        gnt_n;
    logic [SEL_W-1:0]    idx_n;

    logic [SIZE-1:0]     src [N];
    logic [N-1:0]        owner_oh;
    logic [N-1:0]        others;
    logic [SEL_W-1:0]    next_start;
    logic [SEL_W:0]      scan;

    for (genvar i = 0; i < N; i++) begin : g_src
        assign src[i] = IN[i*SIZE +: SIZE];
    end

    // Round-robin scan: first set bit of req starting at index start and
    // wrapping modulo N. Result is {found, index}.
    function automatic logic [SEL_W:0] rr_scan(input logic [N-1:0]     req,
                                               input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!found && ((req >> j) & N'(1)) != '0) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
        return {found, idx};
    endfunction

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            OUT      <= '0;
            VALID    <= 1'b0;
            GNT      <= '0;
            GNT_IDX  <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            OUT      <= out_n;
            VALID    <= valid_n;
            GNT      <= gnt_n;
            GNT_IDX  <= idx_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_n     = hold_cnt;
        out_n      = OUT;
        valid_n    = 1'b0;
        gnt_n      = '0;
        idx_n      = '0;
        scan       = '0;
        owner_oh   = N'(1) << GNT_IDX;
        // The owner's own request is masked during a forced re-arbitration
        // so it can never win back the bus it is being forced to release.
        others     = REQ & ~owner_oh;
        next_start = (GNT_IDX == LAST_IDX) ? '0 : GNT_IDX + 1'b1;

        if (!MODE) begin
            // Direct select: arbiter parked in IDLE, pointer preserved.
            state_n = IDLE;
            hold_n  = '0;
            if ({1'b0, SEL} < N_EXT) begin
                valid_n = 1'b1;
                idx_n   = SEL;
            end else begin
                out_n = '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    scan = rr_scan(REQ, ptr);
                    if (scan[SEL_W]) begin
                        state_n = OWNED;
                        hold_n  = HOLD_W'(1);
                        valid_n = 1'b1;
                        idx_n   = scan[SEL_W-1:0];
                    end
                end
                OWNED: begin
                    if ((REQ & owner_oh) != '0 &&
                        (others == '0 || hold_cnt < HOLD_MAX)) begin
                        valid_n = 1'b1;
                        idx_n   = GNT_IDX;
                        if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + 1'b1;
                    end else begin
                        // Release: hand over on this same edge if anyone
                        // else is waiting, otherwise fall back to IDLE.
                        ptr_n = next_start;
                        scan  = rr_scan(others, next_start);
                        if (scan[SEL_W]) begin
                            hold_n  = HOLD_W'(1);
                            valid_n = 1'b1;
                            idx_n   = scan[SEL_W-1:0];
                        end else begin
                            state_n = IDLE;
                            hold_n  = '0;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    hold_n  = '0;
                end
            endcase
        end

        if (valid_n) begin
            gnt_n = N'(1) << idx_n;
            for (int i = 0; i < N; i++) begin
                if (idx_n == SEL_W'(i)) out_n = src[i];
            end
        end
    end

endmodule
